// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one Datapath among NUM_REQ requesters.
// Drives the start/instruction/finished handshake and aborts hung transactions via a watchdog.
module dp_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned RESULT_W = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*INSTR_W-1:0] req_instr,
  output logic [NUM_REQ-1:0]         ack,
  output logic [RESULT_W-1:0]        resp_result,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_error,
  output logic                       busy,
  output logic                       dp_start,
  output logic [INSTR_W-1:0]         dp_instruction,
  input  logic [RESULT_W-1:0]        dp_result,
  input  logic                       dp_finished
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StIssue    = 3'd1;
  localparam logic [2:0] StWaitBusy = 3'd2;
  localparam logic [2:0] StWaitDone = 3'd3;
  localparam logic [2:0] StRespond  = 3'd4;

  localparam logic [15:0]     TimeoutVal = 16'(TIMEOUT);
  localparam logic [ID_W-1:0] LastInit   = ID_W'(NUM_REQ - 1);

  logic [2:0]          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [15:0]         wd_q, wd_d, wd_inc;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                err_q, err_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic [INSTR_W-1:0]  instr_arr [NUM_REQ];
  logic                rr_found;
  logic [ID_W-1:0]     rr_winner;
  int unsigned         rr_idx;
  logic                respond, abort;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign instr_arr[g] = req_instr[g*INSTR_W +: INSTR_W];
  end

  // First pending request strictly after the last grant, wrapping around.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    rr_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      rr_idx = (32'(last_q) + k) % NUM_REQ;
      if (!rr_found && req_valid[rr_idx[ID_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = rr_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    wd_d     = wd_q;
    instr_d  = instr_q;
    result_d = result_q;
    id_d     = id_q;
    err_d    = err_q;
    ack_d    = '0;
    start_d  = 1'b0;
    respond  = 1'b0;
    abort    = 1'b0;
    wd_inc   = wd_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        // Only issue once the Datapath reports idle.
        if (rr_found && dp_finished) begin
          grant_d = rr_winner;
          last_d  = rr_winner;
          instr_d = instr_arr[rr_winner];
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        wd_d = wd_inc;
        if (wd_inc >= TimeoutVal) abort = 1'b1;
        else if (!dp_finished)    state_d = StWaitDone;
      end
      StWaitDone: begin
        wd_d = wd_inc;
        if (dp_finished) begin
          result_d = dp_result;
          err_d    = 1'b0;
          respond  = 1'b1;
        end else if (wd_inc >= TimeoutVal) begin
          abort = 1'b1;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (respond || abort) begin
      state_d = StRespond;
      ack_d   = NUM_REQ'(1) << grant_q;
      id_d    = grant_q;
      if (abort) begin
        result_d = '0;
        err_d    = 1'b1;
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= LastInit;
      wd_q     <= '0;
      instr_q  <= '0;
      result_q <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_q     <= wd_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      id_q     <= id_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign ack            = ack_q;
  assign resp_result    = result_q;
  assign resp_id        = id_q;
  assign resp_error     = err_q;
  assign busy           = busy_q;
  assign dp_start       = start_q;
  assign dp_instruction = instr_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter with a small behavioural Datapath responder.
module tb_dp_arbiter;

  localparam int unsigned NumReq = 4;
  localparam int unsigned IdW    = 2;
  localparam int unsigned InstrW = 32;
  localparam int unsigned ResW   = 12;

  logic                     clock = 1'b0;
  logic                     resetn = 1'b1;
  logic [NumReq-1:0]        req_valid;
  logic [NumReq*InstrW-1:0] req_instr;
  logic [NumReq-1:0]        ack;
  logic [ResW-1:0]          resp_result;
  logic [IdW-1:0]           resp_id;
  logic                     resp_error;
  logic                     busy;
  logic                     dp_start;
  logic [InstrW-1:0]        dp_instruction;
  logic [ResW-1:0]          dp_result;
  logic                     dp_finished;

  // Datapath model controls
  logic            fin_q, m_block, m_hang, m_run;
  logic [ResW-1:0] res_q, m_res;
  int unsigned     m_cnt, m_lat;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int unsigned cyc = 0;
  int unsigned start_cyc, ack_cyc;
  logic [31:0] ack_q[$];
  logic [31:0] id_q[$];
  logic [31:0] res_qq[$];
  logic [31:0] err_q[$];
  logic [31:0] start_q[$];

  dp_arbiter #(
    .NUM_REQ (NumReq),
    .ID_W    (IdW),
    .INSTR_W (InstrW),
    .RESULT_W(ResW),
    .TIMEOUT (8)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_instr     (req_instr),
    .ack           (ack),
    .resp_result   (resp_result),
    .resp_id       (resp_id),
    .resp_error    (resp_error),
    .busy          (busy),
    .dp_start      (dp_start),
    .dp_instruction(dp_instruction),
    .dp_result     (dp_result),
    .dp_finished   (dp_finished)
  );

  always #5 clock = ~clock;

  assign dp_finished = fin_q & ~m_block;
  assign dp_result   = res_q;

  // Datapath: drops finished on the start edge, raises it m_lat edges later.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fin_q <= 1'b1;
      res_q <= '0;
      m_run <= 1'b0;
      m_cnt <= 0;
    end else if (dp_start) begin
      fin_q <= 1'b0;
      m_run <= 1'b1;
      m_cnt <= m_lat;
    end else if (m_run && !m_hang) begin
      if (m_cnt <= 1) begin
        fin_q <= 1'b1;
        res_q <= m_res;
        m_run <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (ack != '0) begin
      ack_q.push_back(32'(ack));
      id_q.push_back(32'(resp_id));
      res_qq.push_back(32'(resp_result));
      err_q.push_back(32'(resp_error));
      ack_cyc = cyc;
    end
    if (dp_start) begin
      start_q.push_back(dp_instruction);
      start_cyc = cyc;
      check("start_while_finished", 32'(dp_finished), 32'd1);
    end
  end

  task automatic clear_logs();
    ack_q.delete(); id_q.delete(); res_qq.delete(); err_q.delete(); start_q.delete();
  endtask

  task automatic set_instr(input int i, input logic [31:0] v);
    req_instr[i*InstrW +: InstrW] = v;
  endtask

  task automatic wait_acks(input int n, input int budget);
    for (int i = 0; i < budget && ack_q.size() < n; i++) begin
      @(posedge clock);
      #1;
    end
    check("ack_count", 32'(ack_q.size()), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = '0;
    req_instr = '0;
    m_block   = 1'b0;
    m_hang    = 1'b0;
    m_lat     = 1;
    m_res     = '0;

    // Reset values
    #3 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_start", 32'(dp_start), 32'h0);
    check("rst_instr", dp_instruction, 32'h0);
    check("rst_result", 32'(resp_result), 32'h0);
    check("rst_id_err", 32'({resp_id, resp_error}), 32'h0);
    @(negedge clock) resetn = 1'b1;

    // Single read from requester 2, cycle-exact
    m_res = 12'hABC;
    set_instr(2, 32'h2000_0010);
    @(negedge clock) req_valid = 4'b0100;
    @(posedge clock) #1;
    check("rd_start", 32'(dp_start), 32'h1);
    check("rd_instr", dp_instruction, 32'h2000_0010);
    check("rd_busy0", 32'(busy), 32'h1);
    @(posedge clock) #1;
    check("rd_start_off", 32'(dp_start), 32'h0);
    @(posedge clock) #1;
    check("rd_no_ack_yet", 32'(ack), 32'h0);
    check("rd_busy2", 32'(busy), 32'h1);
    @(posedge clock) #1;
    check("rd_ack", 32'(ack), 32'h4);
    check("rd_id", 32'(resp_id), 32'd2);
    check("rd_result", 32'(resp_result), 32'hABC);
    check("rd_err", 32'(resp_error), 32'h0);
    check("rd_busy3", 32'(busy), 32'h1);
    req_valid = '0;
    @(posedge clock) #1;
    check("rd_ack_off", 32'(ack), 32'h0);
    check("rd_busy_off", 32'(busy), 32'h0);
    check("rd_result_held", 32'(resp_result), 32'hABC);
    check("rd_instr_held", dp_instruction, 32'h2000_0010);

    // Reset while waiting for a slow Datapath
    clear_logs();
    m_lat = 5;
    set_instr(1, 32'h1000_0020);
    @(negedge clock) req_valid = 4'b0010;
    repeat (4) @(posedge clock);
    #1;
    check("mid_busy", 32'(busy), 32'h1);
    resetn    = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_instr", dp_instruction, 32'h0);
    check("mid_rst_result", 32'(resp_result), 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check("mid_no_ack", 32'(ack_q.size()), 32'd0);

    // All four continuously requesting
    clear_logs();
    m_lat = 1;
    for (int i = 0; i < 4; i++) set_instr(i, 32'h3000_0000 + 32'(i));
    @(negedge clock) req_valid = 4'b1111;
    wait_acks(6, 150);
    req_valid = '0;
    for (int k = 0; k < 6 && k < ack_q.size(); k++) begin
      check("rr_id", id_q[k], 32'(k % 4));
      check("rr_ack", ack_q[k], 32'd1 << (k % 4));
      check("rr_instr", start_q[k], 32'h3000_0000 + 32'(k % 4));
    end

    // Datapath not ready at request time
    clear_logs();
    m_block = 1'b1;
    m_res   = 12'h5A5;
    set_instr(3, 32'h4000_0030);
    @(negedge clock) req_valid = 4'b1000;
    repeat (6) @(posedge clock);
    #1;
    check("blk_no_start", 32'(start_q.size()), 32'd0);
    check("blk_busy", 32'(busy), 32'h0);
    m_block = 1'b0;
    wait_acks(1, 30);
    req_valid = '0;
    if (ack_q.size() > 0) begin
      check("blk_ack", ack_q[0], 32'h8);
      check("blk_result", res_qq[0], 32'h5A5);
      check("blk_err", err_q[0], 32'h0);
    end

    // Hung Datapath trips the watchdog
    clear_logs();
    m_hang = 1'b1;
    set_instr(1, 32'h1000_0040);
    @(negedge clock) req_valid = 4'b0010;
    wait_acks(1, 40);
    req_valid = '0;
    if (ack_q.size() > 0) begin
      check("hang_ack", ack_q[0], 32'h2);
      check("hang_err", err_q[0], 32'h1);
      check("hang_result", res_qq[0], 32'h0);
      check("hang_latency", 32'(ack_cyc - start_cyc), 32'd9);
    end

    // Recovery once the Datapath finishes
    m_hang = 1'b0;
    clear_logs();
    m_res = 12'h123;
    set_instr(0, 32'h2000_0050);
    @(negedge clock) req_valid = 4'b0001;
    wait_acks(1, 30);
    req_valid = '0;
    if (ack_q.size() > 0) begin
      check("rec_ack", ack_q[0], 32'h1);
      check("rec_result", res_qq[0], 32'h123);
      check("rec_err", err_q[0], 32'h0);
    end

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
